display_req_arbiter: RTL and testbench
======================================

// Module: display_req_arbiter
// PURPOSE
//   Shares one 7-segment digit among NREQ push-button requesters.
//   - Debounces each raw request line.
//   - Grants the digit to one requester at a time, in round-robin order, for a minimum hold time.
//   - Drives the 3-bit digit code (requester index+1, 0 = none) to the one-digit display driver.
//   - Sits between the board buttons and the display path, replacing the purely combinational one-hot encoder.
// PARAMETERS
//   NREQ        6   number of requesters (1..7; code must fit in 3 bits)
//   DEB_CYCLES  4   consecutive stable synchronised cycles needed to accept a level change (>=1)
//   HOLD_CYCLES 8   minimum cycles a grant is held before re-arbitration (>=1)
// PORTS
//   clk         in   1     system clock, rising edge
//   rst_n       in   1     asynchronous active-low reset
//   req         in   NREQ  raw button levels (asynchronous, may bounce)
//   grant       out  NREQ  one-hot grant, all-zero when idle (registered)
//   code        out  3     granted index+1 (req[0]->1 .. req[5]->6), 0 when idle (registered)
//   code_valid  out  1     1 while grant is non-zero (registered)
//   req_db      out  NREQ  debounced request levels, for observation (registered)
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - All outputs are 0: grant=0, code=0, code_valid=0, req_db=0.
//     - State=IDLE, rr_ptr=NREQ-1 (so req[0] wins first), hold_cnt=0, sync flops and debounce counters=0.
//   Synchroniser: two flops per request line.
//   Debounce (per line):
//     - The counter increments while sync value != req_db[i], and clears when they are equal.
//     - When the counter would reach DEB_CYCLES, req_db[i] toggles and the counter clears.
//     - Raw edge held steady -> req_db changes on edge 2+DEB_CYCLES.
//     - A glitch shorter than DEB_CYCLES synchronised cycles never reaches req_db.
//   Round-robin pick:
//     - Search starts at rr_ptr+1 modulo NREQ; the first index with req_db=1 wins.
//     - rr_ptr is loaded with the winner index when a grant is issued.
//   FSM:
//     IDLE: if any req_db=1 -> HOLD; grant/code/code_valid register the winner on that edge;
//           hold_cnt=HOLD_CYCLES-1. Otherwise outputs stay 0.
//     HOLD: hold_cnt decrements each cycle. Grant is held regardless of req_db.
//           At hold_cnt==0, re-arbitrate excluding the current owner:
//       - another req_db pending -> grant the next RR winner, hold_cnt reloads, stay in HOLD;
//       - none pending, owner req_db=1 -> keep grant, hold_cnt reloads;
//       - none pending, owner req_db=0 -> IDLE; grant=0, code=0, code_valid=0 on the same edge.
//   Latency: raw req rise, steady, from IDLE -> grant on edge 3+DEB_CYCLES (7 at defaults).
//   Simultaneous requests: one grant only, chosen by the RR order above; never more than one grant bit set.
//   Owner drops during hold: grant stays until hold_cnt==0 (no early release).
//   Reset mid-HOLD: outputs go to 0 immediately; after release, arbitration restarts with req[0] favoured.
//   Width rule: code = winner index + 1, zero-extended to 3 bits.
//     code and grant always agree; code_valid == |grant.
// TESTING
//   1 reset: rst_n=0 with req=6'h3F -> grant=0, code=0, code_valid=0, req_db=0; hold rst_n=0 for 5 cycles, outputs stay 0.
//   2 single: req=6'b000100 steady from IDLE -> req_db[2]=1 at edge 6, grant=6'b000100/code=3 at edge 7;
//     release req -> grant=0, code=0 once hold expires and req_db[2]=0.
//   3 bounce: req[1] toggles every 2 cycles for 20 cycles, then goes low -> req_db[1] stays 0, code stays 0 throughout.
//   4 round-robin: req=6'b100101 held -> code sequence 1,3,6,1 with each value lasting exactly HOLD_CYCLES=8 cycles.
//   5 hold/extend: grant to req[4] (code=5), req[4] released after 2 cycles -> grant held to 8 cycles, then IDLE;
//     with req[4] held alone -> code=5 continuous.
//   6 reset mid-HOLD: assert rst_n=0 while code=3 -> code=0 asynchronously;
//     after release with req=6'b001001 -> first code=1.

Source files
------------

// File: rtl/display_req_arbiter.sv
// Round-robin arbiter that shares one 7-segment digit among NREQ debounced push-button requesters.
// Each grant lasts at least HOLD_CYCLES cycles. The outputs are registered, and code is the index+1 of the owner.
module display_req_arbiter #(
  parameter int NREQ        = 6,
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      code,
  output logic            code_valid,
  output logic [NREQ-1:0] req_db
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [NREQ-1:0] sync1;
  logic [NREQ-1:0] sync2;
  logic [DW-1:0]   deb_cnt [NREQ];
  logic [0:0]      state;
  logic [2:0]      rr_ptr;
  logic [HW-1:0]   hold_cnt;
  logic            pick_found;
  logic [2:0]      pick_idx;
  logic [3:0]      cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= req;
      sync2 <= sync1;
    end
  end

  // A line toggles only after DEB_CYCLES consecutive synchronised cycles that disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_db <= '0;
      for (int i = 0; i < NREQ; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (sync2[i] == req_db[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          req_db[i]  <= ~req_db[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // The search starts after the last winner. While in HOLD, the final slot is the current owner, so it is skipped.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!pick_found && req_db[cand[2:0]] && (k < NREQ || state == ST_IDLE)) begin
        pick_found = 1'b1;
        pick_idx   = cand[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= 3'(NREQ - 1);
      hold_cnt   <= '0;
      grant      <= '0;
      code       <= '0;
      code_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            state      <= ST_HOLD;
            rr_ptr     <= pick_idx;
            hold_cnt   <= HW'(HOLD_CYCLES - 1);
            grant      <= NREQ'(1) << pick_idx;
            code       <= pick_idx + 3'd1;
            code_valid <= 1'b1;
          end
        end
        default: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else if (pick_found) begin
            rr_ptr     <= pick_idx;
            hold_cnt   <= HW'(HOLD_CYCLES - 1);
            grant      <= NREQ'(1) << pick_idx;
            code       <= pick_idx + 3'd1;
            code_valid <= 1'b1;
          end else if (req_db[rr_ptr]) begin
            hold_cnt <= HW'(HOLD_CYCLES - 1);
          end else begin
            state      <= ST_IDLE;
            grant      <= '0;
            code       <= '0;
            code_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_req_arbiter.sv
// Randomized and directed bench for display_req_arbiter. A behavioural model predicts every output on every cycle,
// and directed scenarios add hard-coded expectations.
module tb_display_req_arbiter;

  localparam int NREQ = 6;
  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] grant;
  logic [2:0]      code;
  logic            code_valid;
  logic [NREQ-1:0] req_db;

  int checks = 0;
  int errors = 0;

  logic [NREQ-1:0] rawq[$];
  logic [NREQ-1:0] m_db;
  int              m_owner;
  int              m_remain;
  int              m_last;

  display_req_arbiter #(.NREQ(NREQ), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .grant      (grant),
    .code       (code),
    .code_valid (code_valid),
    .req_db     (req_db)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rrPick(input int last, input logic [NREQ-1:0] db, input int exclude);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (last + k) % NREQ;
      if (idx != exclude && db[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic modelReset();
    rawq.delete();
    for (int i = 0; i < DEB + 2; i++) rawq.push_back('0);
    m_db     = '0;
    m_owner  = -1;
    m_remain = 0;
    m_last   = NREQ - 1;
  endtask

  // The raw sample taken two edges ago is what the debouncer sees now. It flips after DEB disagreeing samples in a row.
  task automatic modelStep(input logic [NREQ-1:0] r);
    logic [NREQ-1:0] old_db;
    logic            flip;
    int              w;
    old_db = m_db;
    if (m_owner < 0) begin
      w = rrPick(m_last, old_db, -1);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_remain = HOLD - 1;
      end
    end else if (m_remain > 0) begin
      m_remain--;
    end else begin
      w = rrPick(m_last, old_db, m_owner);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_remain = HOLD - 1;
      end else if (old_db[m_owner]) begin
        m_remain = HOLD - 1;
      end else begin
        m_owner = -1;
      end
    end
    rawq.push_back(r);
    void'(rawq.pop_front());
    for (int i = 0; i < NREQ; i++) begin
      flip = 1'b1;
      for (int j = 0; j < DEB; j++) if (rawq[j][i] == m_db[i]) flip = 1'b0;
      if (flip) m_db[i] = ~m_db[i];
    end
  endtask

  task automatic checkAll();
    logic [NREQ-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    checkOutput("grant", 32'(grant), 32'(eg));
    checkOutput("code", 32'(code), (m_owner >= 0) ? 32'(m_owner + 1) : 32'd0);
    checkOutput("code_valid", 32'(code_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    checkOutput("req_db", 32'(req_db), 32'(m_db));
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input int n);
    for (int c = 0; c < n; c++) begin
      req = r;
      @(posedge clk);
      modelStep(r);
      #1;
      checkAll();
    end
  endtask

  // Asserts reset between clock edges so that the asynchronous clear can be observed before any edge arrives.
  task automatic doReset(input logic [NREQ-1:0] r, input int n);
    req   = r;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkOutput("async_clear_code", 32'(code), 32'd0);
    repeat (n) begin
      @(posedge clk);
      #1;
      checkAll();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0] cur;
    int              line;

    $display("[TB] reset with all requests high");
    modelReset();
    req = 6'h3F;
    #1;
    checkAll();
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("reset_code", 32'(code), 32'd0);
      checkOutput("reset_req_db", 32'(req_db), 32'd0);
      checkAll();
    end

    $display("[TB] single requester latency");
    doReset('0, 2);
    for (int e = 1; e <= 7; e++) begin
      applyStimulus(6'b000100, 1);
      if (e == 5) checkOutput("single_db_e5", 32'(req_db), 32'd0);
      if (e == 6) checkOutput("single_db_e6", 32'(req_db), 32'b000100);
      if (e == 6) checkOutput("single_code_e6", 32'(code), 32'd0);
      if (e == 7) checkOutput("single_grant_e7", 32'(grant), 32'b000100);
      if (e == 7) checkOutput("single_code_e7", 32'(code), 32'd3);
    end
    applyStimulus('0, 20);
    checkOutput("single_release", 32'(code), 32'd0);

    $display("[TB] bouncing request");
    doReset('0, 2);
    cur = '0;
    for (int t = 0; t < 10; t++) begin
      cur[1] = ~cur[1];
      for (int c = 0; c < 2; c++) begin
        applyStimulus(cur, 1);
        checkOutput("bounce_db", 32'(req_db[1]), 32'd0);
        checkOutput("bounce_code", 32'(code), 32'd0);
      end
    end
    applyStimulus('0, 10);
    checkOutput("bounce_end", 32'(code), 32'd0);

    $display("[TB] round robin sequence");
    doReset('0, 2);
    for (int e = 1; e <= 31; e++) begin
      applyStimulus(6'b100101, 1);
      if (e >= 7 && e <= 14) checkOutput("rr_code1", 32'(code), 32'd1);
      if (e >= 15 && e <= 22) checkOutput("rr_code3", 32'(code), 32'd3);
      if (e >= 23 && e <= 30) checkOutput("rr_code6", 32'(code), 32'd6);
      if (e == 31) checkOutput("rr_wrap", 32'(code), 32'd1);
    end

    $display("[TB] hold after early release");
    doReset('0, 2);
    for (int e = 1; e <= 16; e++) begin
      applyStimulus((e <= 8) ? 6'b010000 : 6'b000000, 1);
      if (e >= 7 && e <= 14) checkOutput("hold_code5", 32'(code), 32'd5);
      if (e >= 15) checkOutput("hold_idle", 32'(code), 32'd0);
    end

    $display("[TB] hold extended by steady owner");
    doReset('0, 2);
    for (int e = 1; e <= 40; e++) begin
      applyStimulus(6'b010000, 1);
      if (e >= 7) checkOutput("extend_code5", 32'(code), 32'd5);
    end

    $display("[TB] reset in the middle of a hold");
    doReset('0, 2);
    applyStimulus(6'b000100, 10);
    checkOutput("midhold_code3", 32'(code), 32'd3);
    doReset(6'b001001, 2);
    for (int e = 1; e <= 7; e++) begin
      applyStimulus(6'b001001, 1);
      if (e == 6) checkOutput("after_reset_e6", 32'(code), 32'd0);
      if (e == 7) checkOutput("after_reset_first", 32'(code), 32'd1);
    end

    $display("[TB] randomized traffic");
    cur = '0;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        doReset(cur, $urandom_range(1, 3));
      end else if ($urandom_range(0, 3) == 0) begin
        line = $urandom_range(0, NREQ - 1);
        for (int t = 0; t < $urandom_range(2, 6); t++) begin
          cur[line] = ~cur[line];
          applyStimulus(cur, $urandom_range(1, 3));
        end
      end else begin
        cur = NREQ'($urandom);
        if ($urandom_range(0, 1) == 0) cur = cur & NREQ'($urandom);
        applyStimulus(cur, $urandom_range(1, 20));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
